// File: rtl/hl5_rd_stream_pkg.sv
// Shared definitions for the hl5_rd_stream burst reader: memory size,
// state encoding, burst length width and the request range check.
package hl5_rd_stream_pkg;

    localparam int unsigned LEN_W     = 16;
    localparam logic [31:0] MEM_WORDS = 32'd51200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // True when words [first, first+len) all lie inside the memory.
    function automatic logic in_range(input logic [31:0] first, input logic [LEN_W-1:0] len);
        return (first + 32'(len)) <= MEM_WORDS;
    endfunction

endpackage

// File: rtl/hl5_rd_stream_fifo.sv
// Output FIFO for hl5_rd_stream: synchronous, cleared by RSTN, DEPTH x W.
// The head word is presented combinationally and forced to zero when empty.
// The reader never pushes when full, so there is no overflow guard here.
module hl5_rd_stream_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_eff;

    assign valid_o = (count_q != '0);
    assign pop_eff = pop_i && valid_o;
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    // Storage array: written on push, contents qualified by count_q.
    always_ff @(posedge CLK) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_eff) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_i, pop_eff})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/hl5_rd_stream.sv
// hl5_rd_stream: streams a burst of words from a 1w1r memory read port into a
// valid/ready output through a small FIFO, keeping at most FIFO_DEPTH reads
// outstanding so the FIFO can never overflow.
// Handshake: a word transfers on a cycle where out_valid && out_ready; out_data
// is held stable while out_valid && !out_ready.
// Optional feature macro HL5_RD_STREAM_STATS_EN adds the stall_cnt output.
module hl5_rd_stream
    import hl5_rd_stream_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              CE1,
    output logic [ADDR_W-1:0] A1,
    input  logic [DATA_W-1:0] Q1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef HL5_RD_STREAM_STATS_EN
    output logic [31:0]       stall_cnt,
`endif
    output state_e            dbg_state_o
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    state_e            state_q;
    logic              ce_q;
    logic [ADDR_W-1:0] a_q;
    logic [ADDR_W-1:0] next_addr_q;
    logic [LEN_W-1:0]  left_q;      // words not yet scheduled for a read
    logic              inflight_q;  // a read was issued last cycle; Q1 is valid now
    logic [CNT_W-1:0]  outst_q;     // issued reads not yet popped (FIFO + in flight)
    logic [CNT_W-1:0]  outst_d;
    logic              done_q;
    logic              err_q;
    logic              pop;
    logic              start_ok;
    logic              can_issue;

    assign pop       = out_valid && out_ready;
    assign outst_d   = outst_q + CNT_W'(ce_q) - CNT_W'(pop);
    assign can_issue = outst_d < DEPTH_C;
    assign start_ok  = (length != '0) && in_range(32'(base_addr), length);

    assign CE1         = ce_q;
    assign A1          = a_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

    // Burst control FSM; CE1/A1 are registered so each read is decided one
    // cycle ahead using the occupancy that will hold in that cycle.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            ce_q        <= 1'b0;
            a_q         <= '0;
            next_addr_q <= '0;
            left_q      <= '0;
            inflight_q  <= 1'b0;
            outst_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ce_q       <= 1'b0;
            a_q        <= '0;
            inflight_q <= ce_q;
            outst_q    <= outst_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            done_q <= 1'b1;
                        end else if (!start_ok) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q     <= RUN;
                            ce_q        <= 1'b1;
                            a_q         <= base_addr;
                            next_addr_q <= base_addr + ADDR_W'(1);
                            left_q      <= length - LEN_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (left_q == '0) begin
                        state_q <= DRAIN;
                    end else if (can_issue) begin
                        ce_q        <= 1'b1;
                        a_q         <= next_addr_q;
                        next_addr_q <= next_addr_q + ADDR_W'(1);
                        left_q      <= left_q - LEN_W'(1);
                    end
                end
                DRAIN: begin
                    if (pop && (outst_q == CNT_W'(1))) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    hl5_rd_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .push_i      (inflight_q),
        .push_data_i (Q1),
        .pop_i       (pop),
        .valid_o     (out_valid),
        .data_o      (out_data)
    );

`ifdef HL5_RD_STREAM_STATS_EN
    logic [31:0] stall_q;
    assign stall_cnt = stall_q;

    // Saturating count of backpressured cycles during a burst.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            stall_q <= '0;
        end else if ((state_q == IDLE) && start && start_ok) begin
            stall_q <= '0;
        end else if ((state_q != IDLE) && out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end
`endif

endmodule
